// File: rtl/axis_mem_sink.sv
// axis_mem_sink
//   Captures one AXI-Stream packet into a small on-chip memory and holds it
//   until software releases it with a single-cycle clear. The stored packet
//   can be read back at any time through a registered read port.
//
// Parameters
//   DEPTH   number of storage entries (power of two, >= 2)
//   DATA_W  stream data width in bits
//
// Ports
//   clk       rising-edge clock
//   resetn    asynchronous, active-low reset
//   s_tvalid  upstream beat valid
//   s_tdata   upstream beat data
//   s_tlast   marks final beat of a packet
//   s_tready  sink ready (registered); low while a packet is held
//   clear     single-cycle release / abort request
//   rd_addr   readback address
//   rd_data   readback data, one-cycle latency (registered)
//   pkt_done  a complete packet is held in memory
//   pkt_len   number of beats stored, saturating at DEPTH
//   overflow  sticky: the packet had more than DEPTH beats
module axis_mem_sink #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              clear,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              pkt_done,
  output logic [AW:0]       pkt_len,
  output logic              overflow
);

  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;

  logic beat;
  logic wr_en;
  logic ovf_set;
  logic clr_cnt;

  // s_tready is itself a register, so a beat is exactly a valid/ready overlap.
  assign beat = s_tvalid & s_tready;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. clear wins over any concurrent beat in IDLE and RECV,
  // which is what makes a simultaneous beat get swallowed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clear) begin
          next_state = IDLE;
        end else if (beat) begin
          next_state = s_tlast ? DONE : RECV;
        end
      end
      RECV: begin
        if (clear) begin
          next_state = IDLE;
        end else if (beat && s_tlast) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath controls decoded from the state. In IDLE wr_ptr is always zero,
  // so the first beat lands at address 0 without special casing. Once the
  // packet has filled memory further beats are accepted but only flag
  // overflow.
  always_comb begin
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    clr_cnt = 1'b0;
    case (state)
      IDLE: begin
        wr_en = beat & ~clear;
      end
      RECV: begin
        clr_cnt = clear;
        if (beat && !clear) begin
          if (pkt_len < LEN_FULL) begin
            wr_en = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      DONE: begin
        clr_cnt = clear;
      end
      default: ;
    endcase
  end

  // Registered outputs and counters. s_tready and pkt_done follow the state
  // being entered so they line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_tready <= 1'b0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      s_tready <= (next_state != DONE);
      pkt_done <= (next_state == DONE);
      if (clr_cnt) begin
        pkt_len  <= '0;
        overflow <= 1'b0;
        wr_ptr   <= '0;
      end else begin
        if (wr_en) begin
          pkt_len <= pkt_len + LEN_ONE;
          wr_ptr  <= wr_ptr + PTR_ONE;
        end
        if (ovf_set) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Storage array, deliberately not reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Registered read port; a read of the address being written this cycle
  // returns the previous contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axis_mem_sink.sv
// tb_axis_mem_sink
//   Directed self-checking bench for axis_mem_sink with DEPTH=8, DATA_W=8.
//   Inputs change one time unit after each rising edge and outputs are
//   sampled at that same point, well away from the active edge.
module tb_axis_mem_sink;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              resetn;
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              s_tready;
  logic              clear;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pkt_done;
  logic [AW:0]       pkt_len;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt1 [8] = '{8'd16, 8'd17, 8'd29, 8'd31, 8'd59, 8'd60, 8'd65, 8'd30};
  logic [7:0] pkt4 [4] = '{8'h3C, 8'h4D, 8'h5E, 8'h6F};

  axis_mem_sink #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_tvalid(s_tvalid),
    .s_tdata (s_tdata),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .clear   (clear),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pkt_done(pkt_done),
    .pkt_len (pkt_len),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic l, input logic c);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    clear    = c;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Point the read port at addr, idle one cycle, then check the data.
  task automatic readCheck(input int addr, input logic [31:0] exp, input string tag);
    rd_addr = AW'(addr);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput(tag, 32'(rd_data), exp);
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, "_tready"}, 32'(s_tready), 32'd1);
    checkOutput({tag, "_done"},   32'(pkt_done), 32'd0);
    checkOutput({tag, "_len"},    32'(pkt_len),  32'd0);
    checkOutput({tag, "_ovf"},    32'(overflow), 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    clear    = 1'b0;
    rd_addr  = '0;

    // Reset state
    #3;
    checkOutput("rst_tready", 32'(s_tready), 32'd0);
    checkOutput("rst_done",   32'(pkt_done), 32'd0);
    checkOutput("rst_len",    32'(pkt_len),  32'd0);
    checkOutput("rst_ovf",    32'(overflow), 32'd0);
    checkOutput("rst_rdata",  32'(rd_data),  32'd0);
    tick();
    tick();
    resetn = 1'b1;
    checkOutput("rel_tready_low", 32'(s_tready), 32'd0);
    tick();
    checkOutput("rel_tready_high", 32'(s_tready), 32'd1);

    // Eight-beat packet filling memory exactly
    $display("[TB] full packet");
    for (int i = 0; i < 8; i++) begin
      checkOutput("p1_tready", 32'(s_tready), 32'd1);
      applyStimulus(1'b1, pkt1[i], (i == 7), 1'b0);
      checkOutput("p1_len", 32'(pkt_len), 32'(i + 1));
    end
    s_tvalid = 1'b0;
    checkOutput("p1_done",   32'(pkt_done), 32'd1);
    checkOutput("p1_ovf",    32'(overflow), 32'd0);
    checkOutput("p1_tready", 32'(s_tready), 32'd0);
    for (int a = 0; a < 8; a++) begin
      readCheck(a, 32'(pkt1[a]), "p1_rd");
    end

    // Beat offered while DONE is refused and memory untouched
    $display("[TB] beat while done, then clear");
    rd_addr = '0;
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("done_tready", 32'(s_tready), 32'd0);
    checkOutput("done_len",    32'(pkt_len),  32'd8);
    checkOutput("done_hold",   32'(pkt_done), 32'd1);
    readCheck(0, 32'd16, "done_mem0");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkIdleCleared("clr1");
    clear = 1'b0;

    // Single-beat packet; same-address read returns old contents
    $display("[TB] single beat");
    rd_addr = '0;
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    checkOutput("sb_rd_old", 32'(rd_data),  32'd16);
    checkOutput("sb_done",   32'(pkt_done), 32'd1);
    checkOutput("sb_len",    32'(pkt_len),  32'd1);
    checkOutput("sb_tready", 32'(s_tready), 32'd0);
    readCheck(0, 32'hA5, "sb_rd_new");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkIdleCleared("clr2");

    // Ten-beat packet overflows an eight-entry memory
    $display("[TB] overflow packet");
    for (int i = 1; i <= 10; i++) begin
      checkOutput("ov_tready", 32'(s_tready), 32'd1);
      applyStimulus(1'b1, 8'(i), (i == 10), 1'b0);
      checkOutput("ov_len", 32'(pkt_len),  (i > 8) ? 32'd8 : 32'(i));
      checkOutput("ov_flag", 32'(overflow), (i > 8) ? 32'd1 : 32'd0);
    end
    s_tvalid = 1'b0;
    checkOutput("ov_done", 32'(pkt_done), 32'd1);
    for (int a = 0; a < 8; a++) begin
      readCheck(a, 32'(a + 1), "ov_rd");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkIdleCleared("clr3");

    // Four beats with valid gaps
    $display("[TB] gapped packet");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pkt4[i], (i == 3), 1'b0);
      checkOutput("gap_len", 32'(pkt_len), 32'(i + 1));
      if (i < 3) begin
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
        checkOutput("gap_hold", 32'(pkt_len), 32'(i + 1));
      end
    end
    checkOutput("gap_done", 32'(pkt_done), 32'd1);
    for (int a = 0; a < 4; a++) begin
      readCheck(a, 32'(pkt4[a]), "gap_rd");
    end
    readCheck(4, 32'd5, "gap_stale");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkIdleCleared("clr4");

    // Abort in RECV with a concurrent beat, then clear in IDLE with a beat
    $display("[TB] abort");
    applyStimulus(1'b1, 8'h70, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
    checkOutput("ab_len2", 32'(pkt_len), 32'd2);
    applyStimulus(1'b1, 8'h72, 1'b0, 1'b1);
    checkIdleCleared("ab");
    readCheck(2, 32'h5E, "ab_mem2");
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkIdleCleared("idle_clr");
    readCheck(0, 32'h70, "idle_mem0");

    // Reset in the middle of a packet
    $display("[TB] reset mid-packet");
    rd_addr = '0;
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    checkOutput("mr_len3",  32'(pkt_len), 32'd3);
    checkOutput("mr_rdata", 32'(rd_data), 32'hA1);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("mr_tready", 32'(s_tready), 32'd0);
    checkOutput("mr_len",    32'(pkt_len),  32'd0);
    checkOutput("mr_done",   32'(pkt_done), 32'd0);
    checkOutput("mr_ovf",    32'(overflow), 32'd0);
    checkOutput("mr_rd",     32'(rd_data),  32'd0);
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("mr_tready_up", 32'(s_tready), 32'd1);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    s_tvalid = 1'b0;
    checkOutput("np_len",  32'(pkt_len),  32'd2);
    checkOutput("np_done", 32'(pkt_done), 32'd1);
    readCheck(0, 32'h11, "np_rd0");
    readCheck(1, 32'h22, "np_rd1");
    readCheck(2, 32'hA3, "np_stale2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
